// File: rtl/segre_pkg.sv
// Shared types and constants for the history-file rollback controller.
package segre_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_RESTORE  = 2'd2,
        ST_REDIRECT = 2'd3
    } rollback_state_e;

    typedef logic [3:0] exc_cause_t;

    localparam int unsigned HF_PTR = 4;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_2000;

endpackage

// File: rtl/segre_rollback_watchdog.sv
// Rollback watchdog: counts enabled cycles down from LIMIT-1; expiry sets a
// sticky timeout flag that only reset clears.
module segre_rollback_watchdog #(
    parameter int unsigned LIMIT = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clear_i,
    output logic expired_o,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LOAD = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Expires on the LIMIT-th consecutive enabled cycle.
    assign expired_o = en_i && !clear_i && (cnt_q == '0);
    assign timeout_d = timeout_q | expired_o;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= LOAD;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/segre_hf_rollback_ctrl.sv
// Precise-exception recovery: drains the pipeline, replays history-file
// entries into the register file youngest-first, then redirects to the trap vector.
module segre_hf_rollback_ctrl #(
    parameter int unsigned REG_SIZE     = 5,
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned ADDR_SIZE    = 32,
    parameter int unsigned HF_PTR       = segre_pkg::HF_PTR,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [ADDR_SIZE-1:0] TRAP_VECTOR = ADDR_SIZE'(segre_pkg::TRAP_VECTOR_DEFAULT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 exc_i,
    input  logic [HF_PTR-1:0]    exc_id_i,
    input  logic [ADDR_SIZE-1:0] exc_pc_i,
    input  logic [3:0]           exc_cause_i,
    input  logic                 hf_recovering_i,
    input  logic                 hf_empty_i,
    input  logic [REG_SIZE-1:0]  hf_dest_reg_i,
    input  logic [WORD_SIZE-1:0] hf_value_i,
    output logic                 hf_pop_o,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_wdata_o,
    output logic                 flush_o,
    output logic                 stall_fetch_o,
    output logic                 redirect_o,
    output logic [ADDR_SIZE-1:0] redirect_pc_o,
    output logic [ADDR_SIZE-1:0] epc_o,
    output logic [3:0]           ecause_o,
    output logic [HF_PTR-1:0]    exc_id_o,
    output logic [HF_PTR:0]      restored_cnt_o,
    output logic                 timeout_o
);

    import segre_pkg::*;

    localparam int unsigned CNT_W    = HF_PTR + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1 << HF_PTR);
    localparam int unsigned WD_LIMIT = (1 << HF_PTR) + 4;

    rollback_state_e       state_q, state_d;
    logic [3:0]            drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]      restored_cnt_q, restored_cnt_d;
    logic [ADDR_SIZE-1:0]  epc_q, epc_d;
    exc_cause_t            ecause_q, ecause_d;
    logic [HF_PTR-1:0]     exc_id_q, exc_id_d;
    logic                  first_q, first_d;

    logic in_restore;
    logic wd_clear;
    logic wd_expired;
    logic wd_timeout;
    logic pop;

    assign in_restore = (state_q == ST_RESTORE);
    assign wd_clear   = !in_restore;
    assign pop        = in_restore && hf_recovering_i && !hf_empty_i;

    segre_rollback_watchdog #(
        .LIMIT(WD_LIMIT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (in_restore),
        .clear_i  (wd_clear),
        .expired_o(wd_expired),
        .timeout_o(wd_timeout)
    );

    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        restored_cnt_d = restored_cnt_q;
        epc_d          = epc_q;
        ecause_d       = ecause_q;
        exc_id_d       = exc_id_q;
        first_d        = first_q;

        unique case (state_q)
            ST_IDLE: begin
                if (exc_i) begin
                    epc_d          = exc_pc_i;
                    ecause_d       = exc_cause_i;
                    exc_id_d       = exc_id_i;
                    restored_cnt_d = '0;
                    drain_cnt_d    = 4'(FLUSH_CYCLES - 1);
                    state_d        = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    first_d = 1'b1;
                    state_d = ST_RESTORE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            ST_RESTORE: begin
                first_d = 1'b0;
                if (pop && (restored_cnt_q != CNT_MAX)) begin
                    restored_cnt_d = restored_cnt_q + CNT_W'(1);
                end
                // An empty file on entry means nothing to replay, regardless of recovering.
                if (wd_expired || (hf_empty_i && (!hf_recovering_i || first_q))) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            drain_cnt_q    <= '0;
            restored_cnt_q <= '0;
            epc_q          <= '0;
            ecause_q       <= '0;
            exc_id_q       <= '0;
            first_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            restored_cnt_q <= restored_cnt_d;
            epc_q          <= epc_d;
            ecause_q       <= ecause_d;
            exc_id_q       <= exc_id_d;
            first_q        <= first_d;
        end
    end

    assign hf_pop_o       = pop;
    assign rf_we_o        = pop && (hf_dest_reg_i != '0);
    assign rf_waddr_o     = pop ? hf_dest_reg_i : '0;
    assign rf_wdata_o     = pop ? hf_value_i : '0;
    assign flush_o        = (state_q == ST_DRAIN);
    assign stall_fetch_o  = (state_q != ST_IDLE);
    assign redirect_o     = (state_q == ST_REDIRECT);
    assign redirect_pc_o  = TRAP_VECTOR;
    assign epc_o          = epc_q;
    assign ecause_o       = ecause_q;
    assign exc_id_o       = exc_id_q;
    assign restored_cnt_o = restored_cnt_q;
    assign timeout_o      = wd_timeout;

endmodule
